// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    // Scanner operating states.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    // Hex code printed on each key, indexed [row][col].
    localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Look up the code of the key at (row, col).
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[row][col];
    endfunction

    // Index of the lowest-numbered active-low row; 0 when none is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for asynchronous inputs, one independent chain per bit.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            // Shift the raw input through two stages to settle metastability.
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= RESET_VAL[gi];
                    sync_reg <= RESET_VAL[gi];
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns, debounces rows, emits one
// hex code and a single valid pulse per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // One counter serves both the column dwell and the debounce timing,
    // since those never run at the same time.
    localparam int CNT_W  = (SCAN_W > DEB_W) ? SCAN_W : DEB_W;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       row_s;
    kp_state_t        state_reg, state_next;
    logic [1:0]       col_reg, col_next;
    logic [1:0]       row_reg, row_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       key_reg, key_next;
    logic             valid_reg, valid_next;
    logic             held_reg, held_next;
    logic             row_hit;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (row_s)
    );

    // Register all scanner state; reset returns to scanning column 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SCAN;
            col_reg   <= 2'd0;
            row_reg   <= 2'd0;
            cnt_reg   <= '0;
            key_reg   <= 4'h0;
            valid_reg <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            cnt_reg   <= cnt_next;
            key_reg   <= key_next;
            valid_reg <= valid_next;
            held_reg  <= held_next;
        end
    end

    // Next-state logic: scan, qualify a press, track it, qualify the release.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        cnt_next   = cnt_reg;
        key_next   = key_reg;
        valid_next = 1'b0;
        held_next  = held_reg;
        // Only the latched row of the frozen column matters once a key is seen.
        row_hit    = ~row_s[row_reg];

        case (state_reg)
            SCAN: begin
                if (cnt_reg == SCAN_LAST) begin
                    cnt_next = '0;
                    if (row_s != 4'b1111) begin
                        // Column stays where it is; remember which row fired.
                        row_next   = lowest_low_row(row_s);
                        state_next = DEBOUNCE;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            DEBOUNCE: begin
                if (!row_hit) begin
                    // Bounce: give up and continue with the next column.
                    state_next = SCAN;
                    col_next   = col_reg + 2'd1;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    key_next   = key_code(row_reg, col_reg);
                    valid_next = 1'b1;
                    held_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = HELD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            HELD: begin
                if (!row_hit) begin
                    cnt_next   = '0;
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                if (row_hit) begin
                    // Release was a bounce; the key is still down, no new pulse.
                    state_next = HELD;
                end else if (cnt_reg == DEB_LAST) begin
                    held_next  = 1'b0;
                    col_next   = col_reg + 2'd1;
                    cnt_next   = '0;
                    state_next = SCAN;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: begin
                state_next = SCAN;
            end
        endcase
    end

    assign col_n     = ~(4'b0001 << col_reg);
    assign key       = key_reg;
    assign key_valid = valid_reg;
    assign key_held  = held_reg;

endmodule
